// File: rtl/bus_timer_responder_pkg.sv
// rtl/bus_timer_responder_pkg.sv - shared constants and byte-lane helper for the bus timer
package bus_timer_responder_pkg;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'hFF20_0500;
   localparam logic [31:0] ZERO              = 32'h0000_0000;

   // Byte offsets inside the 32-byte register window
   localparam logic [4:0] OFS_TIME_LO = 5'h00;
   localparam logic [4:0] OFS_TIME_HI = 5'h04;
   localparam logic [4:0] OFS_CMP_LO  = 5'h08;
   localparam logic [4:0] OFS_CMP_HI  = 5'h0C;
   localparam logic [4:0] OFS_CTRL    = 5'h10;
   localparam logic [4:0] OFS_STATUS  = 5'h14;

   // CTRL bit positions
   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;

   // Replace only the byte lanes selected by be; the rest keep old_val
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_timer_responder_prescaler.sv
// rtl/bus_timer_responder_prescaler.sv - prescaler counter producing one time tick every PRESCALE enabled clocks
module bus_timer_responder_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic iCLK,
   input  logic iRST,
   input  logic iEnable,
   input  logic iClear,
   output logic oTick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] count_q;
   logic [15:0] count_d;

   // A tick is the enabled cycle on which the counter sits at its last value
   assign oTick = iEnable && (count_q == LAST);

   // Next count: clear has priority, then wrap on tick, else advance while enabled
   always_comb begin
      count_d = count_q;
      if (iClear) begin
         count_d = '0;
      end else if (oTick) begin
         count_d = '0;
      end else if (iEnable) begin
         count_d = count_q + 16'd1;
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge iCLK) begin
      if (iRST) count_q <= '0;
      else      count_q <= count_d;
   end

endmodule

// File: rtl/bus_timer_responder.sv
// rtl/bus_timer_responder.sv - memory-mapped 64-bit timer/compare responder; optional BUS_TIMER_SNAPSHOT_EN adds tear-free TIME_HI snapshot
module bus_timer_responder
   import bus_timer_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReadEnable,
   input  logic        iWriteEnable,
   input  logic [3:0]  iByteEnable,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   output logic [31:0] oReadData,
   output logic        oHit,
   output logic        oIRQ
);

   logic [63:0] time_q, time_d;
   logic [63:0] cmp_q,  cmp_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        pend_q, pend_d;

   logic [4:0]  offset;
   logic        rd_sel;
   logic        wr_sel;
   logic        ctrl_wr;
   logic        tick;
   logic        match;
   logic        unused_addr_bits;

   assign oHit     = (iAddress[31:5] == BASE_ADDR[31:5]);
   assign offset   = {iAddress[4:2], 2'b00};
   assign rd_sel   = iReadEnable  & oHit;
   assign wr_sel   = iWriteEnable & oHit;
   assign ctrl_wr  = wr_sel && (offset == OFS_CTRL);
   assign match    = (time_q >= cmp_q);
   assign oIRQ     = pend_q & ctrl_q[CTRL_IE];
   assign unused_addr_bits = ^iAddress[1:0];

   bus_timer_responder_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iEnable (ctrl_q[CTRL_EN]),
      .iClear  (ctrl_wr),
      .oTick   (tick)
   );

`ifdef BUS_TIMER_SNAPSHOT_EN
   logic [31:0] snap_q, snap_d;

   // Reading TIME_LO captures the live upper word so a following TIME_HI read cannot tear
   always_comb begin
      snap_d = snap_q;
      if (rd_sel && (offset == OFS_TIME_LO)) snap_d = time_q[63:32];
   end

   // Snapshot register
   always_ff @(posedge iCLK) begin
      if (iRST) snap_q <= '0;
      else      snap_q <= snap_d;
   end
`endif

   // Combinational read mux; returns ZERO unless a selected read is in progress
   always_comb begin
      oReadData = ZERO;
      if (rd_sel) begin
         case (offset)
            OFS_TIME_LO: oReadData = time_q[31:0];
`ifdef BUS_TIMER_SNAPSHOT_EN
            OFS_TIME_HI: oReadData = snap_q;
`else
            OFS_TIME_HI: oReadData = time_q[63:32];
`endif
            OFS_CMP_LO:  oReadData = cmp_q[31:0];
            OFS_CMP_HI:  oReadData = cmp_q[63:32];
            OFS_CTRL:    oReadData = {30'd0, ctrl_q};
            OFS_STATUS:  oReadData = {31'd0, pend_q};
            default:     oReadData = ZERO;
         endcase
      end
   end

   // Register-file next state; a time write suppresses the tick so unwritten bytes keep their pre-tick value
   always_comb begin
      time_d = time_q;
      cmp_d  = cmp_q;
      ctrl_d = ctrl_q;
      pend_d = pend_q;

      if (wr_sel && (offset == OFS_TIME_LO)) begin
         time_d[31:0] = byte_merge(time_q[31:0], iWriteData, iByteEnable);
      end else if (wr_sel && (offset == OFS_TIME_HI)) begin
         time_d[63:32] = byte_merge(time_q[63:32], iWriteData, iByteEnable);
      end else if (tick) begin
         time_d = time_q + 64'd1;
      end

      if (wr_sel && (offset == OFS_CMP_LO)) begin
         cmp_d[31:0] = byte_merge(cmp_q[31:0], iWriteData, iByteEnable);
      end
      if (wr_sel && (offset == OFS_CMP_HI)) begin
         cmp_d[63:32] = byte_merge(cmp_q[63:32], iWriteData, iByteEnable);
      end

      if (ctrl_wr && iByteEnable[0]) begin
         ctrl_d = iWriteData[1:0];
      end

      if (wr_sel && (offset == OFS_STATUS) && iByteEnable[0] && iWriteData[0]) begin
         pend_d = 1'b0;
      end
      if (match) begin
         pend_d = 1'b1;
      end
   end

   // State registers with synchronous reset; reset overrides any same-cycle write
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         time_q <= '0;
         cmp_q  <= '1;
         ctrl_q <= '0;
         pend_q <= 1'b0;
      end else begin
         time_q <= time_d;
         cmp_q  <= cmp_d;
         ctrl_q <= ctrl_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_bus_timer_responder.sv
// tb/tb_bus_timer_responder.sv - self-checking bench: two instances (PRESCALE 4 and 1) against a behavioural model
module tb_bus_timer_responder;

   localparam logic [31:0] BASE = 32'hFF20_0500;
   localparam logic [31:0] A_TLO = BASE + 32'h00;
   localparam logic [31:0] A_THI = BASE + 32'h04;
   localparam logic [31:0] A_CLO = BASE + 32'h08;
   localparam logic [31:0] A_CHI = BASE + 32'h0C;
   localparam logic [31:0] A_CTL = BASE + 32'h10;
   localparam logic [31:0] A_STS = BASE + 32'h14;
   localparam logic [31:0] A_R18 = BASE + 32'h18;
   localparam logic [31:0] A_MISS = 32'hFF20_0520;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;

   logic [31:0] dut_rdata [2];
   logic        dut_hit   [2];
   logic        dut_irq   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(4)) u_dut0 (
      .iCLK(clk), .iRST(rst), .iReadEnable(rd_en), .iWriteEnable(wr_en),
      .iByteEnable(be), .iAddress(addr), .iWriteData(wdata),
      .oReadData(dut_rdata[0]), .oHit(dut_hit[0]), .oIRQ(dut_irq[0]));

   bus_timer_responder #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
      .iCLK(clk), .iRST(rst), .iReadEnable(rd_en), .iWriteEnable(wr_en),
      .iByteEnable(be), .iAddress(addr), .iWriteData(wdata),
      .oReadData(dut_rdata[1]), .oHit(dut_hit[1]), .oIRQ(dut_irq[1]));

   // Behavioural model state: value after the most recent rising edge
   int          m_p    [2] = '{4, 1};
   logic [63:0] m_time [2];
   logic [63:0] m_cmp  [2];
   int          m_pc   [2];
   bit          m_en   [2];
   bit          m_ie   [2];
   bit          m_pend [2];
   logic [31:0] m_snap [2];
   bit          model_valid = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd32);
   endfunction

   function automatic int reg_index(input logic [31:0] a);
      return int'(a - BASE) / 4;
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] b);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input int k);
      if (!(rd_en && in_window(addr))) return 32'h0;
      case (reg_index(addr))
         0: return m_time[k][31:0];
`ifdef BUS_TIMER_SNAPSHOT_EN
         1: return m_snap[k];
`else
         1: return m_time[k][63:32];
`endif
         2: return m_cmp[k][31:0];
         3: return m_cmp[k][63:32];
         4: return {30'd0, m_ie[k], m_en[k]};
         5: return {31'd0, m_pend[k]};
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model across the next rising edge using the inputs now on the bus
   task automatic model_step();
      bit sel, wr, rd, tick, match;
      int idx;
      sel = in_window(addr);
      idx = reg_index(addr);
      wr  = wr_en && sel;
      rd  = rd_en && sel;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_time[k] = 64'd0;
            m_cmp[k]  = {64{1'b1}};
            m_pc[k]   = 0;
            m_en[k]   = 0;
            m_ie[k]   = 0;
            m_pend[k] = 0;
            m_snap[k] = 32'd0;
         end else begin
            tick  = m_en[k] && (m_pc[k] == m_p[k] - 1);
            match = (m_time[k] >= m_cmp[k]);
            if (rd && idx == 0) m_snap[k] = m_time[k][63:32];
            if (wr && idx == 0)      m_time[k][31:0]  = lanes(m_time[k][31:0], wdata, be);
            else if (wr && idx == 1) m_time[k][63:32] = lanes(m_time[k][63:32], wdata, be);
            else if (tick)           m_time[k] = m_time[k] + 64'd1;
            if (wr && idx == 2) m_cmp[k][31:0]  = lanes(m_cmp[k][31:0], wdata, be);
            if (wr && idx == 3) m_cmp[k][63:32] = lanes(m_cmp[k][63:32], wdata, be);
            if (wr && idx == 4)  m_pc[k] = 0;
            else if (m_en[k])    m_pc[k] = (m_pc[k] + 1) % m_p[k];
            if (wr && idx == 4 && be[0]) begin
               m_en[k] = wdata[0];
               m_ie[k] = wdata[1];
            end
            if (wr && idx == 5 && be[0] && wdata[0]) m_pend[k] = 0;
            if (match) m_pend[k] = 1;
         end
      end
      if (rst) model_valid = 1;
   endtask

   // Compare every DUT output against the model, then step the model for the coming edge
   always @(negedge clk) begin
      if (model_valid) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc_hit%0d", k), 64'(dut_hit[k]), 64'(in_window(addr)));
            check($sformatf("cyc_rdata%0d", k), 64'(dut_rdata[k]), 64'(model_read(k)));
            check($sformatf("cyc_irq%0d", k), 64'(dut_irq[k]), 64'(m_pend[k] && m_ie[k]));
         end
      end
      model_step();
   end

   // One bus cycle; entered 1ns after a rising edge, returns 1ns after the next
   task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] q0, output logic [31:0] q1);
      rd_en = r; wr_en = w; addr = a; wdata = d; be = b;
      #3;
      q0 = dut_rdata[0];
      q1 = dut_rdata[1];
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
      logic [31:0] q0, q1;
      bus(1'b0, 1'b1, a, d, b, q0, q1);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] q0, output logic [31:0] q1);
      bus(1'b1, 1'b0, a, 32'h0, 4'h0, q0, q1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] q0, q1;
      int rise_at;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values
      rd(A_TLO, q0, q1); check("rst_time_lo", q0, 0);
      rd(A_THI, q0, q1); check("rst_time_hi", q0, 0);
      rd(A_CLO, q0, q1); check("rst_cmp_lo", q0, 32'hFFFF_FFFF);
      rd(A_CHI, q0, q1); check("rst_cmp_hi", q1, 32'hFFFF_FFFF);
      rd(A_CTL, q0, q1); check("rst_ctrl", q0, 0);
      rd(A_STS, q0, q1); check("rst_status", q0, 0);
      rd(A_R18, q0, q1); check("rst_r18", q0, 0);
      check("rst_irq", dut_irq[0], 0);

      // Prescaled counting and freeze
      wr(A_CTL, 32'h1);
      idle(40);
      rd(A_TLO, q0, q1);
      check("p4_time_after_40", q0, 32'd10);
      check("p1_time_after_40", q1, 32'd40);
      wr(A_CTL, 32'h0);
      idle(10);
      rd(A_TLO, q0, q1);
      check("p4_time_frozen", q0, 32'd10);
      check("p1_time_frozen", q1, 32'd42);

      // Compare and interrupt
      wr(A_TLO, 32'h0);
      wr(A_CLO, 32'd20);
      wr(A_CHI, 32'h0);
      wr(A_CTL, 32'h3);
      rise_at = -1;
      for (int i = 0; i < 100; i++) begin
         #3;
         if (dut_irq[1]) begin
            rise_at = i;
            break;
         end
         @(posedge clk); #1;
      end
      if (rise_at >= 0) begin @(posedge clk); #1; end
      check("p1_irq_rise_cycle", rise_at, 21);
      check("p4_irq_still_low", dut_irq[0], 0);
      wr(A_STS, 32'h1);
      rd(A_STS, q0, q1);
      check("w1c_during_match_keeps_pend", q1, 1);
      check("irq_held", dut_irq[1], 1);
      wr(A_CHI, 32'h1);
      wr(A_STS, 32'h1);
      rd(A_STS, q0, q1);
      check("w1c_clears_pend", q1, 0);
      check("p4_no_pend", q0, 0);
      check("irq_cleared", dut_irq[1], 0);

      // Carry from TIME_LO into TIME_HI
      wr(A_CTL, 32'h0);
      wr(A_THI, 32'h0);
      wr(A_TLO, 32'hFFFF_FFFE);
      wr(A_CTL, 32'h1);
      idle(2);
      wr(A_CTL, 32'h0);
      rd(A_TLO, q0, q1);
      check("p1_carry_lo", q1, 32'd1);
      check("p4_carry_lo", q0, 32'hFFFF_FFFE);
      rd(A_THI, q0, q1);
      check("p1_carry_hi", q1, 32'd1);
      check("p4_carry_hi", q0, 32'd0);

`ifdef BUS_TIMER_SNAPSHOT_EN
      // Snapshot holds TIME_HI from the TIME_LO read across a carry
      wr(A_TLO, 32'hFFFF_FFFF);
      wr(A_THI, 32'h0);
      rd(A_TLO, q0, q1);
      wr(A_CTL, 32'h1);
      idle(1);
      wr(A_CTL, 32'h0);
      rd(A_THI, q0, q1);
      check("snap_hi_before_carry", q1, 32'd0);
      rd(A_TLO, q0, q1);
      rd(A_THI, q0, q1);
      check("snap_hi_after_relatch", q1, 32'd1);
`endif

      // Byte-lane write
      wr(A_CLO, 32'h1122_3344);
      wr(A_CLO, 32'h00AB_0000, 4'b0100);
      rd(A_CLO, q0, q1);
      check("byte_write_cmp_lo", q0, 32'h11AB_3344);

      // Simultaneous read and write: old value returned, new one committed
      bus(1'b1, 1'b1, A_CHI, 32'h5, 4'hF, q0, q1);
      check("rw_returns_old", q0, 32'h1);
      rd(A_CHI, q0, q1);
      check("rw_commits_new", q1, 32'h5);

      // Out-of-window access and reserved offsets
      bus(1'b1, 1'b1, A_MISS, 32'hDEAD_BEEF, 4'hF, q0, q1);
      check("miss_rdata", q0, 32'h0);
      rd(A_CLO, q0, q1);
      check("miss_no_write", q0, 32'h11AB_3344);
      wr(A_R18, 32'hFFFF_FFFF);
      rd(A_R18, q0, q1);
      check("reserved_reads_zero", q1, 32'h0);

      // Reset mid-count overrides a simultaneous write
      wr(A_CTL, 32'h3);
      idle(5);
      rst = 1'b1;
      wr(A_TLO, 32'h1234);
      rst = 1'b0;
      rd(A_TLO, q0, q1);
      check("midreset_time", q1, 32'h0);
      rd(A_CLO, q0, q1);
      check("midreset_cmp", q0, 32'hFFFF_FFFF);
      rd(A_CTL, q0, q1);
      check("midreset_ctrl", q1, 32'h0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_timer_responder.md
# bus_timer_responder

Memory-mapped 64-bit timer that sits on the responder side of the core's data bus, alongside data memory. Decodes read/write requests from the single-cycle datapath. Keeps a prescaled free-running 64-bit time counter and a 64-bit compare register, and raises a sticky interrupt request when time reaches compare. Read data is combinational, so a load completes in the same cycle the core issues it.

## Interface
- BASE_ADDR, 32'hFF20_0500, word-aligned base of the 32-byte register window
- PRESCALE, 1, core clocks per time tick; legal range 1..65535
- iCLK  in  1  core clock; all state updates on the rising edge
- iRST  in  1  reset, synchronous, active-high
- iReadEnable  in  1  bus read strobe
- iWriteEnable  in  1  bus write strobe
- iByteEnable  in  4  byte lanes for writes; bit n selects bits 8n+7:8n
- iAddress  in  32  byte address
- iWriteData  in  32  write data, already lane-aligned by the store unit
- oReadData  out  32  read data; ZERO when not selected
- oHit  out  1  address falls in the window, bits 31:5 equal BASE_ADDR[31:5]; used by the bus read mux
- oIRQ  out  1  timer interrupt request

## Operation
- Register map, offset from BASE_ADDR; bits 1:0 of iAddress are ignored:
  - 0x00 TIME_LO, read/write
  - 0x04 TIME_HI, read/write
  - 0x08 CMP_LO, read/write
  - 0x0C CMP_HI, read/write
  - 0x10 CTRL: bit0 EN (counting), bit1 IE (interrupt enable); other bits read 0
  - 0x14 STATUS: bit0 PEND; write 1 to clear
  - 0x18 and 0x1C read ZERO; writes to them are ignored
- Writes honour iByteEnable per byte. Unselected bytes keep their previous value.
- Reads have no side effects, except the snapshot described under Configuration.
- Prescaler counts 0..PRESCALE-1 while EN=1. On the cycle it holds PRESCALE-1 it wraps to 0 and time increments by 1.
- Time wraps from 2^64-1 to 0 with no flag.
- When EN=0, the prescaler and time both hold.
- Any CTRL write clears the prescaler to 0.
- Write to TIME_LO or TIME_HI in the same cycle as a tick: the written bytes take the write data. All other time bytes keep their pre-tick value, so no increment happens that cycle.
- Compare is unsigned, 64-bit, against the registered time: the match condition is time ≥ cmp.
- PEND sets on any cycle where the match condition holds, regardless of EN.
- A W1C of PEND in the same cycle as a match leaves PEND set (set wins).
- oIRQ = PEND & IE, driven from registers.

## Timing
- Reset values:
  - time = 0, cmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, PEND = 0, prescaler = 0, snapshot = 0
  - oIRQ = 0
  - oReadData = ZERO while iReadEnable = 0
- Read: zero latency; oReadData reflects current register state combinationally from iAddress.
- Write: takes effect at the rising edge; visible to a read in the next cycle.
- Match → PEND: 1 cycle. PEND → oIRQ: combinational (0 cycles).
- A CMP write that creates a match sets PEND at the edge after the write.
- Reset mid-count: all state returns to reset values at the edge where iRST=1. iRST overrides a simultaneous write.
- iReadEnable and iWriteEnable both high to the same address: the read returns the old value and the write commits at the edge.

## Configuration
- BUS_TIMER_SNAPSHOT_EN defined:
  - A read of TIME_LO latches live TIME_HI into a 32-bit snapshot register at that edge.
  - Reads of TIME_HI return the snapshot, giving a tear-free 64-bit read with a LO-then-HI sequence.
  - Writes to TIME_HI still update the live counter.
- BUS_TIMER_SNAPSHOT_EN undefined: no snapshot register; TIME_HI reads return live time[63:32].

## Structure
- Shared package constants:
  - register offsets (OFS_TIME_LO … OFS_STATUS)
  - CTRL bit indices (CTRL_EN, CTRL_IE)
  - ZERO
  - BASE_ADDR default
- One sub-module, timer_prescaler (counter plus tick output), is natural.
- Register file, decode and compare stay in the top module.

## Test plan
- Reset then read all offsets → TIME = 0, CMP = all ones, CTRL = 0, STATUS = 0, oIRQ = 0.
- PRESCALE = 4, write CTRL = 0x1, wait 40 cycles, read TIME_LO → 10 (±1 tick depending on sample edge); write CTRL = 0 → TIME_LO stays frozen.
- Write CMP = 20, CTRL = 0x3, PRESCALE = 1:
  - oIRQ rises the cycle after time reaches 20
  - W1C STATUS while time > 20 → PEND stays 1
  - write CMP_HI = 1 then W1C → oIRQ = 0
- Write TIME = 0x0000_0000_FFFF_FFFE, run 3 ticks → TIME_HI = 1, TIME_LO = 1; with BUS_TIMER_SNAPSHOT_EN, read TIME_LO at LO = 0xFFFF_FFFF, then TIME_HI after the carry → 0.
- Byte write: iByteEnable = 4'b0100, iWriteData = 0x00AB_0000 to CMP_LO = 0x1122_3344 → reads 0x11AB_3344.
- Address 0xFF20_0520 → oHit = 0, oReadData = 0, no state change on write.
